// File: rtl/unsigned_mul_8x8_ha_array_reduce_pkg.sv
// Shared widths and row type for the half-adder array reduction
// that follows the 8x8 partial-product stage.
package unsigned_mul_8x8_ha_array_reduce_pkg;

   localparam int NUM_GROUPS = 4;
   localparam int B_W        = 7;
   localparam int T_W        = 9;
   localparam int G_SHIFT    = 2;
   localparam int PROD_W     = 16;
   localparam int G_W        = 10;
   // Pair sums reach 1019 + 4*1019 = 5095, so they need 13 bits to stay exact.
   localparam int P_W        = 13;
   localparam int S_W        = PROD_W + 1;

   typedef struct packed {
      logic [B_W-1:0] b;
      logic [T_W-1:0] t;
   } ha_row_t;

endpackage

// File: rtl/unsigned_mul_8x8_ha_array_reduce_ha_group_value.sv
// One group value: sum row plus the carry row weighted by 4.
module ha_group_value
   import unsigned_mul_8x8_ha_array_reduce_pkg::*;
(
   input  ha_row_t        row,
   output logic [G_W-1:0] g
);

   assign g = G_W'(row.t) + (G_W'(row.b) << G_SHIFT);

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_reduce.sv
// Two-stage valid/ready reduction of four half-adder row groups into a
// 16-bit product plus the carry-out bit of the 17-bit sum.
module unsigned_mul_8x8_ha_array_reduce
   import unsigned_mul_8x8_ha_array_reduce_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [B_W-1:0]    ha_array_0_b,
   input  logic [B_W-1:0]    ha_array_1_b,
   input  logic [B_W-1:0]    ha_array_2_b,
   input  logic [B_W-1:0]    ha_array_3_b,
   input  logic [T_W-1:0]    ha_array_0_t,
   input  logic [T_W-1:0]    ha_array_1_t,
   input  logic [T_W-1:0]    ha_array_2_t,
   input  logic [T_W-1:0]    ha_array_3_t,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              product_ovf
);

   ha_row_t [NUM_GROUPS-1:0]         rows;
   logic    [NUM_GROUPS-1:0][G_W-1:0] g;

   assign rows[0] = '{ha_array_0_b, ha_array_0_t};
   assign rows[1] = '{ha_array_1_b, ha_array_1_t};
   assign rows[2] = '{ha_array_2_b, ha_array_2_t};
   assign rows[3] = '{ha_array_3_b, ha_array_3_t};

   for (genvar i = 0; i < NUM_GROUPS; i++) begin : g_grp
      ha_group_value u_grp (
         .row (rows[i]),
         .g   (g[i])
      );
   end

   logic           s1_valid;
   logic [P_W-1:0] p01;
   logic [P_W-1:0] p23;
   logic           s2_free;
   logic [S_W-1:0] s_sum;

   assign s2_free  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_free;
   assign s_sum    = S_W'(p01) + (S_W'(p23) << (2 * G_SHIFT));

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         p01         <= '0;
         p23         <= '0;
         out_valid   <= 1'b0;
         product     <= '0;
         product_ovf <= 1'b0;
      end else begin
         // Stage 2 drains first so stage 1 can refill on the same edge.
         if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) {product_ovf, product} <= s_sum;
         end
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               p01 <= P_W'(g[0]) + (P_W'(g[1]) << G_SHIFT);
               p23 <= P_W'(g[2]) + (P_W'(g[3]) << G_SHIFT);
            end
         end
      end
   end

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_reduce.sv
// Directed and streaming checks for the half-adder array reduction pipeline.
module tb_unsigned_mul_8x8_ha_array_reduce;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [3:0][6:0] b = '0;
   logic [3:0][8:0] t = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [15:0]     product;
   logic            product_ovf;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   unsigned_mul_8x8_ha_array_reduce dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ha_array_0_b (b[0]),
      .ha_array_1_b (b[1]),
      .ha_array_2_b (b[2]),
      .ha_array_3_b (b[3]),
      .ha_array_0_t (t[0]),
      .ha_array_1_t (t[1]),
      .ha_array_2_t (t[2]),
      .ha_array_3_t (t[3]),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .product_ovf  (product_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [16:0] ref_s(input logic [3:0][6:0] bb, input logic [3:0][8:0] tt);
      int s = 0;
      for (int i = 0; i < 4; i++) s += (int'(tt[i]) + 4 * int'(bb[i])) << (2 * i);
      return s[16:0];
   endfunction

   // Present one vector with an idle downstream and check the 2-cycle latency.
   task automatic send_one(input string tag, input logic [15:0] ep, input logic eo);
      in_valid = 1'b1;
      #1 chk({tag, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk({tag, "_early"}, out_valid, 0);
      tick();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_prod"}, product, ep);
      chk({tag, "_ovf"}, product_ovf, eo);
      tick();
      chk({tag, "_drain"}, out_valid, 0);
      b = '0;
      t = '0;
   endtask

   logic [16:0] expq[$];
   logic [16:0] e;

   initial begin
      rst = 1'b1;
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_product", product, 0);
      chk("rst_ovf", product_ovf, 0);
      rst = 1'b0;
      tick();
      chk("rst_in_ready", in_ready, 1);

      send_one("zero", 16'h0000, 1'b0);
      t[0] = 9'h001;
      send_one("t0_one", 16'h0001, 1'b0);
      b[3] = 7'h01;
      send_one("b3_one", 16'h0100, 1'b0);
      t[2] = 9'h1FF;
      send_one("t2_max", 16'h1FF0, 1'b0);
      b[1] = 7'h7F;
      send_one("b1_max", 16'h07F0, 1'b0);
      b = {4{7'h7F}};
      t = {4{9'h1FF}};
      send_one("all_max", 16'h5257, 1'b1);

      // Backpressure: A=3, B=0x14, C=0x80 with out_ready low.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      t[0] = 9'd3;
      #1 chk("bp_rdy_a", in_ready, 1);
      tick();
      t = '0; t[1] = 9'd5;
      chk("bp_rdy_b", in_ready, 1);
      tick();
      t = '0; b[2] = 7'd2;
      chk("bp_rdy_c", in_ready, 0);
      chk("bp_a_valid", out_valid, 1);
      chk("bp_a_prod", product, 16'h0003);
      tick();
      chk("bp_hold_rdy", in_ready, 0);
      chk("bp_hold_prod", product, 16'h0003);
      tick();
      chk("bp_hold_prod2", product, 16'h0003);
      out_ready = 1'b1;
      #1 chk("bp_rdy_release", in_ready, 1);
      tick();
      in_valid = 1'b0;
      b = '0;
      chk("bp_b_valid", out_valid, 1);
      chk("bp_b_prod", product, 16'h0014);
      tick();
      chk("bp_c_valid", out_valid, 1);
      chk("bp_c_prod", product, 16'h0080);
      tick();
      chk("bp_empty", out_valid, 0);

      // Reset with two results in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      t[0] = 9'h0AA;
      tick();
      t[0] = 9'h055;
      tick();
      in_valid = 1'b0;
      t = '0;
      chk("mid_full", out_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_prod", product, 0);
      chk("mid_rst_ready", in_ready, 1);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mid_no_stale", out_valid, 0);
      end

      // Full-rate streaming with out_ready held high.
      in_valid = 1'b1;
      for (int k = 0; k < 24; k++) begin
         for (int i = 0; i < 4; i++) begin
            b[i] = 7'($urandom);
            t[i] = 9'($urandom);
         end
         #1;
         chk("tp_in_ready", in_ready, 1);
         if (k >= 2) chk("tp_out_valid", out_valid, 1);
         if (out_valid) begin
            e = expq.pop_front();
            chk("tp_prod", product, e[15:0]);
            chk("tp_ovf", product_ovf, e[16]);
         end
         expq.push_back(ref_s(b, t));
         tick();
      end
      in_valid = 1'b0;

      // Random valid/ready streaming against the reference model.
      begin
         int sent = 0;
         int cyc  = 0;
         while ((sent < 150 || expq.size() != 0) && cyc < 4000) begin
            in_valid  = (sent < 150) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 4; i++) begin
               b[i] = 7'($urandom);
               t[i] = 9'($urandom);
            end
            #1;
            if (out_valid && out_ready) begin
               if (expq.size() == 0) chk("rnd_extra_output", 1, 0);
               else begin
                  e = expq.pop_front();
                  chk("rnd_prod", product, e[15:0]);
                  chk("rnd_ovf", product_ovf, e[16]);
               end
            end
            if (in_valid && in_ready) begin
               expq.push_back(ref_s(b, t));
               sent++;
            end
            tick();
            cyc++;
         end
         chk("rnd_all_sent", sent, 150);
         chk("rnd_queue_empty", expq.size(), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
